// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// ALU, data SRAM request, HI/LO, multiplier and sequential divider.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int STALL_BUS    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS-1:0]    stall,
    output logic                    stallreq_for_ex,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [37:0]             ex_to_id_bus,
    output logic                    inst_is_lw,
    output logic [65:0]             hilo_ex_to_id,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_state_t;

    logic [ID_TO_EX_WD-1:0] id_to_ex_bus_r;

    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [31:0] ex_result;

    logic special;
    logic is_mfhi;
    logic is_mflo;
    logic is_mthi;
    logic is_mtlo;
    logic is_mult;
    logic is_multu;
    logic is_div;
    logic is_divu;
    logic div_req;

    logic [31:0] hi;
    logic [31:0] lo;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;

    div_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dvs_r;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;
    logic [32:0] trial;
    logic [33:0] diff;
    logic        step_ge;
    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic [31:0] fin_q;
    logic [31:0] fin_r;

    logic unused;

    assign {pc, inst, alu_op, sel_src1, sel_src2,
            ram_en, ram_wen, rf_we, rf_waddr,
            sel_rf_res, rdata1, rdata2} = id_to_ex_bus_r;

    // Input register: load, insert bubble, or hold
    always_ff @(posedge clk) begin
        if (rst) begin
            id_to_ex_bus_r <= '0;
        end else if (stall[2] && !stall[3]) begin
            id_to_ex_bus_r <= '0;
        end else if (!stall[2]) begin
            id_to_ex_bus_r <= id_to_ex_bus;
        end
    end

    // Operand 1 select
    always_comb begin
        src1 = '0;
        unique case (1'b1)
            sel_src1[0]: src1 = rdata1;
            sel_src1[1]: src1 = pc;
            sel_src1[2]: src1 = {27'b0, inst[10:6]};
            default:     src1 = '0;
        endcase
    end

    // Operand 2 select
    always_comb begin
        src2 = '0;
        unique case (1'b1)
            sel_src2[0]: src2 = rdata2;
            sel_src2[1]: src2 = {{16{inst[15]}}, inst[15:0]};
            sel_src2[2]: src2 = 32'd8;
            sel_src2[3]: src2 = {16'b0, inst[15:0]};
            default:     src2 = '0;
        endcase
    end

    assign shamt = src1[4:0];

    // One-hot ALU, alu_op[11] is add down to alu_op[0] lui
    always_comb begin
        alu_res = '0;
        unique case (1'b1)
            alu_op[11]: alu_res = src1 + src2;
            alu_op[10]: alu_res = src1 - src2;
            alu_op[9]:  alu_res = {31'b0, $signed(src1) < $signed(src2)};
            alu_op[8]:  alu_res = {31'b0, src1 < src2};
            alu_op[7]:  alu_res = src1 & src2;
            alu_op[6]:  alu_res = ~(src1 | src2);
            alu_op[5]:  alu_res = src1 | src2;
            alu_op[4]:  alu_res = src1 ^ src2;
            alu_op[3]:  alu_res = src2 << shamt;
            alu_op[2]:  alu_res = src2 >> shamt;
            alu_op[1]:  alu_res = $unsigned($signed(src2) >>> shamt);
            alu_op[0]:  alu_res = {src2[15:0], 16'b0};
            default:    alu_res = '0;
        endcase
    end

    assign special  = inst[31:26] == 6'b000000;
    assign is_mfhi  = special && inst[5:0] == 6'b010000;
    assign is_mthi  = special && inst[5:0] == 6'b010001;
    assign is_mflo  = special && inst[5:0] == 6'b010010;
    assign is_mtlo  = special && inst[5:0] == 6'b010011;
    assign is_mult  = special && inst[5:0] == 6'b011000;
    assign is_multu = special && inst[5:0] == 6'b011001;
    assign is_div   = special && inst[5:0] == 6'b011010;
    assign is_divu  = special && inst[5:0] == 6'b011011;
    assign div_req  = is_div || is_divu;

    assign ex_result = is_mfhi ? hi :
                       is_mflo ? lo : alu_res;

    // Sign-extending for mult lets one 64-bit product serve both forms
    assign mul_a = {{32{is_mult & rdata1[31]}}, rdata1};
    assign mul_b = {{32{is_mult & rdata2[31]}}, rdata2};
    assign prod  = mul_a * mul_b;

    // Pending HI/LO write; a finished divide owns the port
    always_comb begin
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_wdata = '0;
        lo_wdata = '0;
        if (state == S_DONE) begin
            hi_we    = 1'b1;
            lo_we    = 1'b1;
            hi_wdata = res_hi;
            lo_wdata = res_lo;
        end else if (is_mult || is_multu) begin
            hi_we    = 1'b1;
            lo_we    = 1'b1;
            hi_wdata = prod[63:32];
            lo_wdata = prod[31:0];
        end else if (is_mthi) begin
            hi_we    = 1'b1;
            hi_wdata = rdata1;
        end else if (is_mtlo) begin
            lo_we    = 1'b1;
            lo_wdata = rdata1;
        end
    end

    // HI/LO commit only when the stage advances
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (!stall[3]) begin
            if (hi_we) hi <= hi_wdata;
            if (lo_we) lo <= lo_wdata;
        end
    end

    assign a_neg   = is_div && rdata1[31];
    assign b_neg   = is_div && rdata2[31];
    assign dvd_abs = a_neg ? -rdata1 : rdata1;
    assign dvs_abs = b_neg ? -rdata2 : rdata2;

    // Restoring step; a zero divisor naturally yields all-ones / dividend
    assign trial    = {rem_r, quo_r[31]};
    assign diff     = {1'b0, trial} - {2'b0, dvs_r};
    assign step_ge  = !diff[33];
    assign step_rem = step_ge ? diff[31:0] : trial[31:0];
    assign step_quo = {quo_r[30:0], step_ge};
    assign fin_q    = neg_q ? -step_quo : step_quo;
    assign fin_r    = neg_r ? -step_rem : step_rem;

    // Divider FSM: capture, 32 shift-subtract steps, hold result
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rem_r  <= '0;
            quo_r  <= '0;
            dvs_r  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (div_req) begin
                        state <= S_BUSY;
                        cnt   <= '0;
                        rem_r <= '0;
                        quo_r <= dvd_abs;
                        dvs_r <= dvs_abs;
                        neg_q <= (a_neg ^ b_neg) && (rdata2 != 32'd0);
                        neg_r <= a_neg;
                    end
                end
                S_BUSY: begin
                    rem_r <= step_rem;
                    quo_r <= step_quo;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state  <= S_DONE;
                        res_hi <= fin_r;
                        res_lo <= fin_q;
                    end
                end
                S_DONE: begin
                    if (!stall[3]) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stallreq_for_ex = (state == S_IDLE && div_req) ||
                             (state == S_BUSY);

    assign hilo_ex_to_id = {hi_we, lo_we, hi_wdata, lo_wdata};

    assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res,
                            rf_we, rf_waddr, ex_result};
    assign ex_to_id_bus  = {rf_we, rf_waddr, ex_result};

    assign data_sram_en    = ram_en;
    assign data_sram_wen   = ram_wen;
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = rdata2;

    assign inst_is_lw = ram_en && sel_rf_res && (ram_wen == 4'b0);

    assign unused = ^{stall[5:4], stall[1:0], inst[25:16],
                      trial[32], diff[32]};

endmodule
